muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit implementing the RV32M operation set, parametrised in operand width.
- Sits beside the ALU in the execute stage. The core issues an operation with a start pulse and holds further instructions while busy is high.
- Result and done are registered and feed the result mux.

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// Define MULDIV_EARLY_EN to retire zero-operand multiplies, divide-by-zero and signed overflow in 2 edges.
module muldiv_unit #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [2:0]         op_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  // Signedness of each operand as decoded from funct3
  logic             a_signed;
  logic             b_signed;
  logic             in_sa;
  logic             in_sb;
  logic [WIDTH-1:0] in_mag_a;
  logic [WIDTH-1:0] in_mag_b;

  assign a_signed = ~(op[0] & (op[1] | op[2]));
  assign b_signed = op[2] ? ~op[0] : ~op[1];
  assign in_sa    = a_signed & a[WIDTH-1];
  assign in_sb    = b_signed & b[WIDTH-1];
  assign in_mag_a = in_sa ? -a : a;
  assign in_mag_b = in_sb ? -b : b;

  logic                 early;
  logic [2*WIDTH-1:0]   init_acc;

`ifdef MULDIV_EARLY_EN
  logic div_zero;
  logic div_ovf;
  logic mul_zero;

  assign div_zero = op[2] && (b == '0);
  assign div_ovf  = op[2] && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  assign mul_zero = !op[2] && ((a == '0) || (b == '0));
  assign early    = div_zero | div_ovf | mul_zero;
  // Preload acc with what the iterations would have produced so FIX is shared
  assign init_acc = div_zero ? {in_mag_a, {WIDTH{1'b0}}} :
                    mul_zero ? '0 : {{WIDTH{1'b0}}, in_mag_a};
`else
  assign early    = 1'b0;
  assign init_acc = {{WIDTH{1'b0}}, in_mag_a};
`endif

  // Multiply step: acc = {partial product, remaining multiplier bits}
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: acc = {remainder, dividend bits left | quotient bits so far}
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_sub;
  logic [WIDTH-1:0]     rem_next;
  logic [2*WIDTH-1:0]   div_next;

  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mag_b};
  assign div_sub   = div_shift[WIDTH-1:0] - mag_b;
  assign rem_next  = div_ge ? div_sub : div_shift[WIDTH-1:0];
  assign div_next  = {rem_next, acc[WIDTH-2:0], div_ge};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;
  logic [WIDTH-1:0]   fix_res;

  assign prod = (sign_a ^ sign_b) ? -acc : acc;
  assign quo  = (mag_b == '0) ? '1 :
                ((sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rmd  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_res = op_q[1] ? rmd : quo;
    if (!op_q[2]) begin
      fix_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_b  <= '0;
      acc    <= '0;
    end else if (kill) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            sign_a <= in_sa;
            sign_b <= in_sb;
            mag_b  <= in_mag_b;
            acc    <= init_acc;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= early ? FIX : CALC;
          end
        end
        CALC: begin
          acc <= op_q[2] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          result <= fix_res;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (WIDTH=32)
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int errors;

`ifdef MULDIV_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  vec_t vecs[20];
  exp_t sb[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic fast;
    fast = (o[2] && y == 32'd0) ||
           ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ||
           (!o[2] && (x == 32'd0 || y == 32'd0));
    return (EARLY && fast) ? 1 : 33;
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, ux, uy, r;
    sx = $signed({{32{x[31]}}, x});
    sy = $signed({{32{y[31]}}, y});
    ux = $signed({32'd0, x});
    uy = $signed({32'd0, y});
    case (o)
      3'd0:    r = sx * sy;
      3'd1:    r = (sx * sy) >>> 32;
      3'd2:    r = (sx * uy) >>> 32;
      3'd3:    r = (ux * uy) >>> 32;
      3'd4:    r = (y == 32'd0) ? -64'sd1 : sx / sy;
      3'd5:    r = (y == 32'd0) ? -64'sd1 : ux / uy;
      3'd6:    r = (y == 32'd0) ? sx : sx % sy;
      default: r = (y == 32'd0) ? sx : ux % uy;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic drive_start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] r);
    exp_t e;
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    e.res = r;
    e.lat = exp_lat(o, x, y);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int   k;
    exp_t e;
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty actual=done required=expectation", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_done"}, 32'(done), 32'd1);
      chk({name, "_latency"}, 32'(k), 32'(e.lat));
      chk({name, "_result"}, result, e.res);
      chk({name, "_busy_low"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int n_done;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    start = 1'b0;
    kill = 1'b0;
    op = 3'd0;
    a = 32'd0;
    b = 32'd0;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'd3,          32'hFFFF_FFFD};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd3,          32'hFFFF_FFFF};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'd3,          32'h0000_0002};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd3,          32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF};
    vecs[6]  = '{3'd5, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC};
    vecs[7]  = '{3'd7, 32'hFFFF_FFF9, 32'd2,          32'h0000_0001};
    vecs[8]  = '{3'd5, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF};
    vecs[9]  = '{3'd7, 32'h0000_1234, 32'd0,          32'h0000_1234};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000};
    vecs[12] = '{3'd4, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF};
    vecs[13] = '{3'd6, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB};
    vecs[14] = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'h3FFF_FFFF};
    vecs[15] = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'h0000_0001};
    vecs[16] = '{3'd4, 32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2};
    vecs[17] = '{3'd6, 32'd100,       32'hFFFF_FFF9,  32'h0000_0002};
    vecs[18] = '{3'd6, 32'hFFFF_FF9C, 32'd7,          32'hFFFF_FFFE};
    vecs[19] = '{3'd1, 32'd0,         32'h1234_5678,  32'h0000_0000};

    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 20; i++) begin
      drive_start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);
      wait_done($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      drive_start(o, x, y, ref_model(o, x, y));
      wait_done($sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of MUL 7*6
    op = 3'd0;
    a = 32'd7;
    b = 32'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midreset_no_done", 32'(n_done), 32'd0);

    // start while busy (CALC cycle 5 and the FIX cycle) is ignored
    op = 3'd5;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    @(negedge clk);
    n_done = 0;
    for (int j = 0; j < 80; j++) begin
      start = (j == 5 || j == 32);
      op = (j == 0) ? 3'd5 : 3'd0;
      a = (j == 0) ? 32'd100 : 32'd2;
      b = (j == 0) ? 32'd7 : 32'd3;
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) chk("busy_start_result", result, 32'd14);
      end
    end
    start = 1'b0;
    chk("busy_start_single_done", 32'(n_done), 32'd1);
    chk("busy_start_idle", 32'(busy), 32'd0);

    // kill at CALC iteration 10 of DIV 100/7
    op = 3'd4;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'd0);
    n_done = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("kill_no_done", 32'(n_done), 32'd0);
    chk("kill_result_kept", result, 32'd14);

    // kill and start together in IDLE
    op = 3'd0;
    a = 32'd3;
    b = 32'd3;
    start = 1'b1;
    kill = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kill = 1'b0;
    chk("kill_start_busy", 32'(busy), 32'd0);
    n_done = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("kill_start_no_done", 32'(n_done), 32'd0);
    chk("kill_start_result", result, 32'd14);

    // Back-to-back: start in the done cycle is accepted
    drive_start(3'd0, 32'd5, 32'd7, 32'd35);
    wait_done("b2b_first");
    drive_start(3'd5, 32'd1000, 32'd10, 32'd100);
    chk("b2b_done_pulse_low", 32'(done), 32'd0);
    wait_done("b2b_second");
    @(negedge clk);
    chk("b2b_done_single", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
